// File: rtl/alu_op_issue.sv
// Decode/issue stage for RV32I OP, OP-IMM, LUI and AUIPC instructions. It feeds the ALU operands and
// the ctrl code through a two-entry skid buffer, so in_ready comes straight from a register.
module alu_op_issue #(
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic [data_width-1:0] pc,
   input  logic [data_width-1:0] rs1_val,
   input  logic [data_width-1:0] rs2_val,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] alu_a,
   output logic [data_width-1:0] alu_b,
   output logic [2:0]            alu_ctrl,
   output logic [4:0]            rd,
   output logic                  we,
   output logic                  illegal,
   output logic                  err_sticky
);

   localparam int shw = $clog2(data_width);

   typedef struct packed {
      logic [data_width-1:0] a;
      logic [data_width-1:0] b;
      logic [2:0]            ctrl;
      logic [4:0]            rd;
      logic                  we;
      logic                  ill;
   } entry_t;

   typedef enum logic [1:0] {st_empty, st_one, st_two} state_t;

   logic [6:0]                   opcode;
   logic [2:0]                   f3;
   logic [6:0]                   f7;
   logic signed [11:0]           imm_i;
   logic signed [31:0]           imm_u;
   logic [data_width-1:0]        imm_i_ext;
   logic [data_width-1:0]        imm_u_ext;
   logic [data_width-1:0]        shamt_imm;
   logic [data_width-1:0]        rs2_sh;
   logic                         is_op;
   logic                         ok;
   logic [2:0]                   ctrl;
   logic [data_width-1:0]        op_a;
   logic [data_width-1:0]        op_b;
   entry_t                       dec;

   state_t state_reg;
   entry_t main_reg;
   entry_t skid_reg;
   logic   in_ready_reg;
   logic   out_valid_reg;
   logic   err_reg;
   logic   accept;
   logic   pop;

   assign opcode    = instr[6:0];
   assign f3        = instr[14:12];
   assign f7        = instr[31:25];
   assign is_op     = instr[5];
   assign imm_i     = instr[31:20];
   assign imm_u     = {instr[31:12], 12'b0};
   assign imm_i_ext = data_width'(imm_i);
   assign imm_u_ext = data_width'(imm_u);
   assign shamt_imm = data_width'(instr[24:20]);

   // the ALU shifts by the whole of b, so register shift amounts are masked here
   always_comb begin
      rs2_sh = '0;
      rs2_sh[shw-1:0] = rs2_val[shw-1:0];
   end

   always_comb begin
      ok   = 1'b0;
      ctrl = 3'b000;
      op_a = rs1_val;
      op_b = is_op ? rs2_val : imm_i_ext;
      case (opcode)
         7'b0110011, 7'b0010011: begin
            case (f3)
               3'b000: begin
                  if (!is_op || f7 == 7'b0000000) begin
                     ok = 1'b1;
                  end else if (f7 == 7'b0100000) begin
                     ok   = 1'b1;
                     ctrl = 3'b001;
                  end
               end
               3'b111: begin ctrl = 3'b010; ok = !is_op || f7 == 7'b0000000; end
               3'b110: begin ctrl = 3'b011; ok = !is_op || f7 == 7'b0000000; end
               3'b100: begin ctrl = 3'b100; ok = !is_op || f7 == 7'b0000000; end
               3'b001: begin
                  ctrl = 3'b101;
                  ok   = f7 == 7'b0000000;
                  op_b = is_op ? rs2_sh : shamt_imm;
               end
               3'b101: begin
                  ctrl = (f7 == 7'b0100000) ? 3'b111 : 3'b110;
                  ok   = f7 == 7'b0000000 || f7 == 7'b0100000;
                  op_b = is_op ? rs2_sh : shamt_imm;
               end
               default: ok = 1'b0;
            endcase
         end
         7'b0110111: begin ok = 1'b1; op_a = '0; op_b = imm_u_ext; end
         7'b0010111: begin ok = 1'b1; op_a = pc; op_b = imm_u_ext; end
         default:    ok = 1'b0;
      endcase
   end

   // illegal entries still flow through in order, with neutral operands
   always_comb begin
      dec      = '0;
      dec.a    = ok ? op_a : '0;
      dec.b    = ok ? op_b : '0;
      dec.ctrl = ok ? ctrl : 3'b000;
      dec.rd   = instr[11:7];
      dec.we   = ok && (instr[11:7] != 5'd0);
      dec.ill  = !ok;
   end

   assign accept = in_valid & in_ready_reg;
   assign pop    = out_valid_reg & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= st_empty;
         main_reg      <= '0;
         skid_reg      <= '0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (pop && main_reg.ill) begin
            err_reg <= 1'b1;
         end
         case (state_reg)
            st_empty: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  main_reg      <= dec;
                  out_valid_reg <= 1'b1;
                  state_reg     <= st_one;
               end
            end
            st_one: begin
               in_ready_reg <= 1'b1;
               if (accept && !pop) begin
                  skid_reg     <= dec;
                  state_reg    <= st_two;
                  in_ready_reg <= 1'b0;
               end else if (accept) begin
                  main_reg <= dec;
               end else if (pop) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= st_empty;
               end
            end
            st_two: begin
               if (pop) begin
                  main_reg     <= skid_reg;
                  state_reg    <= st_one;
                  in_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= st_empty;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign alu_a      = main_reg.a;
   assign alu_b      = main_reg.b;
   assign alu_ctrl   = main_reg.ctrl;
   assign rd         = main_reg.rd;
   assign we         = main_reg.we;
   assign illegal    = main_reg.ill;
   assign err_sticky = err_reg;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: the driver queues mnemonic-level expectations on every accept,
// and a monitor compares them against each popped output.
module tb_alu_op_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_ctrl;
   logic [4:0]  rd;
   logic        we;
   logic        illegal;
   logic        err_sticky;

   always #5 clk = ~clk;

   alu_op_issue #(.data_width(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid),
      .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
      .we(we), .illegal(illegal), .err_sticky(err_sticky)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t q[$];
   exp_t exp_cur;
   int   total = 0;
   int   bad = 0;
   int   pops = 0;
   logic exp_sticky = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                               input logic [4:0] r, input logic il);
      exp_t e;
      e.a = a; e.b = b; e.ctrl = c; e.rd = r; e.ill = il;
      e.we = !il && (r != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
      return {f7, s2, s1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] d);
      return {imm, s1, f3, d, 7'b0010011};
   endfunction

   // Reference: pick a mnemonic, encode it, and state its meaning in plain arithmetic.
   task automatic gen_rand(output logic [31:0] ins, output exp_t e,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p);
      int          k;
      int          imm;
      logic [4:0]  d, s1, s2, sh;
      logic [11:0] immb;
      logic [19:0] u;
      logic [31:0] junk;
      k = $urandom_range(0, 20);
      d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); sh = 5'($urandom);
      imm = $urandom_range(0, 4095) - 2048;
      immb = imm[11:0];
      u = 20'($urandom);
      junk = $urandom;
      e = mk(r1, r2, 3'd0, d, 1'b0);
      case (k)
         0:  ins = r_type(7'h00, s2, s1, 3'd0, d);
         1:  begin ins = r_type(7'h20, s2, s1, 3'd0, d); e.ctrl = 3'd1; end
         2:  begin ins = r_type(7'h00, s2, s1, 3'd7, d); e.ctrl = 3'd2; end
         3:  begin ins = r_type(7'h00, s2, s1, 3'd6, d); e.ctrl = 3'd3; end
         4:  begin ins = r_type(7'h00, s2, s1, 3'd4, d); e.ctrl = 3'd4; end
         5:  begin ins = r_type(7'h00, s2, s1, 3'd1, d); e.ctrl = 3'd5; e.b = r2 % 32; end
         6:  begin ins = r_type(7'h00, s2, s1, 3'd5, d); e.ctrl = 3'd6; e.b = r2 % 32; end
         7:  begin ins = r_type(7'h20, s2, s1, 3'd5, d); e.ctrl = 3'd7; e.b = r2 % 32; end
         8:  begin ins = i_type(immb, s1, 3'd0, d); e.b = 32'(imm); end
         9:  begin ins = i_type(immb, s1, 3'd7, d); e.b = 32'(imm); e.ctrl = 3'd2; end
         10: begin ins = i_type(immb, s1, 3'd6, d); e.b = 32'(imm); e.ctrl = 3'd3; end
         11: begin ins = i_type(immb, s1, 3'd4, d); e.b = 32'(imm); e.ctrl = 3'd4; end
         12: begin ins = i_type({7'h00, sh}, s1, 3'd1, d); e.b = 32'(sh); e.ctrl = 3'd5; end
         13: begin ins = i_type({7'h00, sh}, s1, 3'd5, d); e.b = 32'(sh); e.ctrl = 3'd6; end
         14: begin ins = i_type({7'h20, sh}, s1, 3'd5, d); e.b = 32'(sh); e.ctrl = 3'd7; end
         15: begin ins = {u, d, 7'b0110111}; e.a = 0; e.b = 32'(u) * 4096; end
         16: begin ins = {u, d, 7'b0010111}; e.a = p; e.b = 32'(u) * 4096; end
         17: begin ins = r_type(7'h00, s2, s1, 3'd2, d); e = mk(0, 0, 3'd0, d, 1'b1); end
         18: begin ins = i_type(immb, s1, 3'd3, d); e = mk(0, 0, 3'd0, d, 1'b1); end
         19: begin ins = r_type(7'h01, s2, s1, 3'd4, d); e = mk(0, 0, 3'd0, d, 1'b1); end
         default: begin ins = {junk[31:12], d, 7'b0000011}; e = mk(0, 0, 3'd0, d, 1'b1); end
      endcase
   endtask

   // Monitor: checks occupancy, stability under backpressure, and pops against the scoreboard.
   initial begin : monitor
      exp_t        e;
      int          since;
      logic        hold_prev;
      logic [31:0] pa, pb;
      logic [9:0]  pm;
      since = 0;
      hold_prev = 1'b0;
      pa = '0; pb = '0; pm = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            exp_sticky = 1'b0;
            hold_prev = 1'b0;
            since = 0;
         end else if (since == 0) begin
            since = 1;
            check("reset_out_valid", out_valid, 0);
            check("reset_in_ready", in_ready, 0);
            check("reset_alu_a", alu_a, 0);
            check("reset_alu_b", alu_b, 0);
            check("reset_misc", {alu_ctrl, rd, we, illegal}, 0);
            check("reset_err_sticky", err_sticky, 0);
         end else begin
            check("err_sticky", err_sticky, exp_sticky);
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < 2);
            if (hold_prev) begin
               check("hold_a", alu_a, pa);
               check("hold_b", alu_b, pb);
               check("hold_misc", {alu_ctrl, rd, we, illegal}, pm);
            end
            if (out_valid && out_ready && q.size() != 0) begin
               e = q.pop_front();
               pops++;
               $display("pop %0d: a=%h b=%h ctrl=%0d rd=%0d we=%0b ill=%0b", pops, alu_a, alu_b,
                        alu_ctrl, rd, we, illegal);
               check("alu_a", alu_a, e.a);
               check("alu_b", alu_b, e.b);
               check("alu_ctrl", alu_ctrl, e.ctrl);
               check("rd", rd, e.rd);
               check("we", we, e.we);
               check("illegal", illegal, e.ill);
               if (e.ill) exp_sticky = 1'b1;
            end
            hold_prev = out_valid && !out_ready;
            pa = alu_a; pb = alu_b; pm = {alu_ctrl, rd, we, illegal};
            if (in_valid && in_ready) q.push_back(exp_cur);
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e);
      int n;
      @(posedge clk); #1;
      instr = ins; pc = p; rs1_val = r1; rs2_val = r2; exp_cur = e; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", q.size(), 0);
   endtask

   initial begin : driver
      logic [31:0] ins;
      exp_t        e;
      int          p0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);

      send(32'h002081B3, 32'h0, 32'd5, 32'd4, mk(32'd5, 32'd4, 3'd0, 5'd3, 1'b0));
      send(32'h407302B3, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 3'd1, 5'd5, 1'b0));
      send(32'h4030D093, 32'h0, 32'hFFFFFE70, 32'd9, mk(32'hFFFFFE70, 32'd3, 3'd7, 5'd1, 1'b0));
      send(32'h003110B3, 32'h0, 32'd7, 32'd33, mk(32'd7, 32'd1, 3'd5, 5'd1, 1'b0));
      send(32'h123450B7, 32'h0, 32'd8, 32'd9, mk(32'd0, 32'h12345000, 3'd0, 5'd1, 1'b0));
      send(32'h12345117, 32'h100, 32'd8, 32'd9, mk(32'h100, 32'h12345000, 3'd0, 5'd2, 1'b0));
      send(32'hFFFFF0B7, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'hFFFFF000, 3'd0, 5'd1, 1'b0));
      send(32'hFFF08013, 32'h0, 32'd6, 32'd2, mk(32'd6, 32'hFFFFFFFF, 3'd0, 5'd0, 1'b0));
      send(32'h003120B3, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, 3'd0, 5'd1, 1'b1));
      drain();
      repeat (3) @(negedge clk);
      check("err_sticky_stays", err_sticky, 1);

      // backpressure: two entries fill the buffer, a third waits
      @(posedge clk); #1 out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd11, 32'd12, mk(32'd11, 32'd12, 3'd0, 5'd3, 1'b0));
      send(32'h407302B3, 32'h0, 32'd21, 32'd22, mk(32'd21, 32'd22, 3'd1, 5'd5, 1'b0));
      @(posedge clk); #1;
      instr = 32'h123450B7; rs1_val = 32'd1; rs2_val = 32'd2;
      exp_cur = mk(32'd0, 32'h12345000, 3'd0, 5'd1, 1'b0);
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         check("full_in_ready_low", in_ready, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      p0 = pops;
      @(negedge clk); #1;
      @(negedge clk); #1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); #1;
      check("pops_one_per_cycle", pops - p0, 3);
      drain();

      // randomized traffic
      repeat (400) begin
         @(posedge clk); #1;
         pc = $urandom; rs1_val = $urandom;
         rs2_val = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 70));
         gen_rand(ins, e, rs1_val, rs2_val, pc);
         instr = ins;
         exp_cur = e;
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      drain();
      check("sticky_before_reset", err_sticky, 1);

      // reset while both entries are held
      @(posedge clk); #1 out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd1, 32'd1, mk(32'd1, 32'd1, 3'd0, 5'd3, 1'b0));
      send(32'h002081B3, 32'h0, 32'd2, 32'd2, mk(32'd2, 32'd2, 3'd0, 5'd3, 1'b0));
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1 check("post_reset_no_stale", out_valid, 0);
      send(32'h00C5F533, 32'h0, 32'hF0F0, 32'h0FF0, mk(32'hF0F0, 32'h0FF0, 3'd2, 5'd10, 1'b0));
      drain();
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
